// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: decoded-pixel bundle produced by ws2812_rx.
// The receiver drives it through the master modport; consumers use the slave modport.
interface ws2812_rx_if;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic [7:0]  pix_idx;
    logic        frame_done;
    logic        bit_err;

    modport master (output pix_valid, pix_data, pix_idx, frame_done, bit_err);
    modport slave  (input  pix_valid, pix_data, pix_idx, frame_done, bit_err);
endinterface

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire receiver/decoder.
// Measures each high pulse of the synchronized data line, decodes it to a bit
// (wide pulse = 1), assembles 24-bit GRB pixels MSB first and detects the long
// low latch gap that ends a frame.
// Optional feature macro WS2812_RX_FWD_EN: adds the dout port, which forwards
// pixels 1..N of each frame so that boards can be daisy-chained.
module ws2812_rx #(
    parameter int OSC_CLK_MHZ   = 50,
    parameter int MIN_HIGH_NS   = 150,
    parameter int BIT_THRESH_NS = 600,
    parameter int MAX_HIGH_NS   = 2000,
    parameter int RES_NS        = 50000
) (
    input  logic        osc_clk,
    input  logic        reset_,
    input  logic        din,
`ifdef WS2812_RX_FWD_EN
    output logic        dout,
`endif
    ws2812_rx_if.master pix
);

    localparam int MIN_CYC    = MIN_HIGH_NS   * OSC_CLK_MHZ / 1000;
    localparam int THRESH_CYC = BIT_THRESH_NS * OSC_CLK_MHZ / 1000;
    localparam int MAX_CYC    = MAX_HIGH_NS   * OSC_CLK_MHZ / 1000;
    localparam int RES_CYC    = RES_NS        * OSC_CLK_MHZ / 1000;
    localparam int CNT_W      = $clog2(RES_CYC + 1);

    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_CYC);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH_CYC);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_CYC);
    localparam logic [CNT_W-1:0] RES_C    = CNT_W'(RES_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_RES = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             din_meta, din_s, din_s_d;
    logic             rise, fall;

    logic             shift_en, end_frame, err_long;
    logic             bit_val, word_done;

    logic [4:0]       bit_cntr;
    logic [22:0]      shreg;

    logic             pix_valid_q, frame_done_q, bit_err_q;
    logic [23:0]      pix_data_q;
    logic [7:0]       pix_idx_q;

    // Two-flop synchronizer for the asynchronous data line, plus a delayed copy for edge detection
    always_ff @(posedge osc_clk or negedge reset_) begin
        if (!reset_) begin
            din_meta <= 1'b0;
            din_s    <= 1'b0;
            din_s_d  <= 1'b0;
        end else begin
            din_meta <= din;
            din_s    <= din_meta;
            din_s_d  <= din_s;
        end
    end

    assign rise = din_s & ~din_s_d;
    assign fall = ~din_s & din_s_d;

    // State and pulse-width counter registers
    always_ff @(posedge osc_clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= WAIT_RES;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: measure highs/lows and raise shift, end-of-frame and overlong-pulse events
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_en  = 1'b0;
        end_frame = 1'b0;
        err_long  = 1'b0;
        case (state_q)
            WAIT_RES: begin
                // Only a full latch gap proves we are between frames
                if (din_s) begin
                    cnt_d = '0;
                end else if (cnt_q >= RES_C) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE: begin
                if (rise) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    // Pulses shorter than the glitch floor leave the shift register alone
                    shift_en = (cnt_q >= MIN_C);
                    cnt_d    = '0;
                    state_d  = LOW;
                end else if (cnt_q >= MAX_C) begin
                    err_long = 1'b1;
                    cnt_d    = '0;
                    state_d  = WAIT_RES;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LOW: begin
                if (rise) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                end else if (cnt_q >= RES_C) begin
                    end_frame = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = WAIT_RES;
            end
        endcase
    end

    assign bit_val   = (cnt_q >= THRESH_C);
    assign word_done = shift_en && (bit_cntr == 5'd23);

    // Bit assembly; the stale contents are flushed by the next 24 shifts, so no reset is needed
    always_ff @(posedge osc_clk) begin
        if (shift_en) begin
            shreg <= {shreg[21:0], bit_val};
        end
    end

    // Bit/pixel counters and registered output strobes
    always_ff @(posedge osc_clk or negedge reset_) begin
        if (!reset_) begin
            bit_cntr     <= 5'd0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            bit_err_q    <= 1'b0;
            pix_data_q   <= 24'd0;
            pix_idx_q    <= 8'd0;
        end else begin
            pix_valid_q  <= word_done;
            frame_done_q <= end_frame;
            // A frame ending with a partial pixel is reported together with frame_done
            bit_err_q    <= err_long | (end_frame && (bit_cntr != 5'd0));
            if (word_done) begin
                pix_data_q <= {shreg, bit_val};
            end
            if (err_long || end_frame) begin
                bit_cntr  <= 5'd0;
                pix_idx_q <= 8'd0;
            end else begin
                if (shift_en) begin
                    bit_cntr <= word_done ? 5'd0 : bit_cntr + 5'd1;
                end
                // Index stays on the strobed pixel for the strobe cycle, then advances (saturating)
                if (pix_valid_q && (pix_idx_q != 8'hFF)) begin
                    pix_idx_q <= pix_idx_q + 8'd1;
                end
            end
        end
    end

    assign pix.pix_valid  = pix_valid_q;
    assign pix.pix_data   = pix_data_q;
    assign pix.pix_idx    = pix_idx_q;
    assign pix.frame_done = frame_done_q;
    assign pix.bit_err    = bit_err_q;

`ifdef WS2812_RX_FWD_EN
    logic fwd_on;

    // Forwarding: swallow pixel 0, then pass the synchronized line through until the frame ends
    always_ff @(posedge osc_clk or negedge reset_) begin
        if (!reset_) begin
            fwd_on <= 1'b0;
            dout   <= 1'b0;
        end else if (err_long || end_frame) begin
            fwd_on <= 1'b0;
            dout   <= 1'b0;
        end else begin
            fwd_on <= fwd_on | word_done;
            dout   <= fwd_on & din_s;
        end
    end
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed bench for ws2812_rx with a transaction-level pixel model.
// Runs the receiver at 20 MHz to keep frame lengths short; thresholds become
// min 3, thresh 12, max 40, latch gap 1000 cycles.
`timescale 1ns/1ps
module tb_ws2812_rx;

    localparam int CLK_MHZ = 20;
    localparam int RES_C   = 50000 * CLK_MHZ / 1000;
    localparam int T0H     = 400 * CLK_MHZ / 1000;
    localparam int T1H     = 800 * CLK_MHZ / 1000;
    localparam int TBIT    = 1250 * CLK_MHZ / 1000;
    localparam int GAP     = RES_C + 50;

    typedef struct {
        logic [23:0] data;
        logic [7:0]  idx;
    } pix_t;

    logic osc_clk = 1'b0;
    logic reset_  = 1'b0;
    logic din     = 1'b0;

    ws2812_rx_if pix ();

`ifdef WS2812_RX_FWD_EN
    logic dout;
    logic ds_dout;
    ws2812_rx_if ds_pix ();
`endif

    ws2812_rx #(.OSC_CLK_MHZ(CLK_MHZ)) dut (
        .osc_clk (osc_clk),
        .reset_  (reset_),
        .din     (din),
`ifdef WS2812_RX_FWD_EN
        .dout    (dout),
`endif
        .pix     (pix)
    );

`ifdef WS2812_RX_FWD_EN
    ws2812_rx #(.OSC_CLK_MHZ(CLK_MHZ)) ds (
        .osc_clk (osc_clk),
        .reset_  (reset_),
        .din     (dout),
        .dout    (ds_dout),
        .pix     (ds_pix)
    );
`endif

    always #25 osc_clk = ~osc_clk;

    int checks   = 0;
    int failures = 0;

    // Model state: pixels the DUT owes us, next index in the frame, last strobed word
    pix_t        exp_q[$];
    int          model_idx = 0;
    logic [23:0] last_data = 24'd0;
    pix_t        cmp_e;

    int pv_cnt = 0, fd_cnt = 0, err_cnt = 0, both_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_pix(input logic [23:0] d);
        pix_t p;
        p.data = d;
        p.idx  = model_idx[7:0];
        exp_q.push_back(p);
        if (model_idx < 255) model_idx++;
    endtask

    task automatic frame_end();
        model_idx = 0;
    endtask

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(posedge osc_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        hold(1'b1, b ? T1H : T0H);
        hold(1'b0, TBIT - (b ? T1H : T0H));
    endtask

    task automatic send_range(input logic [23:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w[i]);
    endtask

    // Compare process: every pix_valid against the model, pix_data held between strobes
    always @(negedge osc_clk) begin
        if (!reset_) begin
            last_data = 24'd0;
        end else begin
            if (pix.pix_valid) begin
                pv_cnt++;
                check("pv_exclusive", {31'd0, pix.frame_done | pix.bit_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pv_unexpected: got data %06h idx %0d, required no strobe",
                             pix.pix_data, pix.pix_idx);
                    last_data = pix.pix_data;
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("pix_data", {8'd0, pix.pix_data}, {8'd0, cmp_e.data});
                    check("pix_idx", {24'd0, pix.pix_idx}, {24'd0, cmp_e.idx});
                    last_data = cmp_e.data;
                end
            end else begin
                check("pix_hold", {8'd0, pix.pix_data}, {8'd0, last_data});
            end
            if (pix.frame_done) fd_cnt++;
            if (pix.bit_err) err_cnt++;
            if (pix.frame_done && pix.bit_err) both_cnt++;
        end
    end

`ifdef WS2812_RX_FWD_EN
    pix_t ds_q[$];
    pix_t ds_e;
    int   ds_pv    = 0;
    bit   ds_arm   = 1'b0;
    bit   fwd_watch = 1'b0;
    int   dout_hi  = 0;

    // Downstream decoder and dout-during-pixel-0 watch
    always @(negedge osc_clk) begin
        if (fwd_watch && dout) dout_hi++;
        if (ds_arm && ds_pix.pix_valid) begin
            ds_pv++;
            if (ds_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL ds_unexpected: got data %06h, required no strobe", ds_pix.pix_data);
            end else begin
                ds_e = ds_q.pop_front();
                check("ds_data", {8'd0, ds_pix.pix_data}, {8'd0, ds_e.data});
                check("ds_idx", {24'd0, ds_pix.pix_idx}, {24'd0, ds_e.idx});
            end
        end
    end
`endif

    initial begin
        int pv0, fd0, err0, both0;
        int pv_at, fd_at;
        logic [7:0]  n8;
        logic [23:0] w;

        // Reset state
        repeat (4) @(posedge osc_clk);
        #1;
        check("rst_pix_valid", {31'd0, pix.pix_valid}, 32'd0);
        check("rst_pix_data", {8'd0, pix.pix_data}, 32'd0);
        check("rst_pix_idx", {24'd0, pix.pix_idx}, 32'd0);
        check("rst_frame_done", {31'd0, pix.frame_done}, 32'd0);
        check("rst_bit_err", {31'd0, pix.bit_err}, 32'd0);
        reset_ = 1'b1;
        hold(1'b0, GAP);

        // One pixel 0xA5C33C, with strobe latency and frame_done window measured
        pv0 = pv_cnt; fd0 = fd_cnt; err0 = err_cnt;
        push_pix(24'hA5C33C);
        send_range(24'hA5C33C, 23, 1);
        hold(1'b1, T0H);
        din = 1'b0;
        pv_at = 0; fd_at = 0;
        for (int i = 1; i <= RES_C + 300; i++) begin
            @(negedge osc_clk);
            if (pix.pix_valid && pv_at == 0) pv_at = i;
            if (pix.frame_done && fd_at == 0) fd_at = i;
        end
        @(posedge osc_clk);
        #1;
        frame_end();
        check("t1_pv_latency", pv_at, 32'd4);
        check("t1_fd_window", {31'd0, (fd_at >= RES_C + 3) && (fd_at <= RES_C + 8)}, 32'd1);
        check("t1_data_lit", {8'd0, pix.pix_data}, 32'h00A5C33C);
        check("t1_pv_count", pv_cnt - pv0, 32'd1);
        check("t1_fd_count", fd_cnt - fd0, 32'd1);
        check("t1_err_count", err_cnt - err0, 32'd0);

        // 64-pixel frame, gap, then a 4-pixel frame: index restarts
        pv0 = pv_cnt; fd0 = fd_cnt; err0 = err_cnt;
        for (int n = 0; n < 64; n++) begin
            n8 = n[7:0];
            w  = {n8, ~n8, n8};
            push_pix(w);
            send_range(w, 23, 0);
        end
        hold(1'b0, GAP);
        frame_end();
        for (int n = 0; n < 4; n++) begin
            n8 = n[7:0];
            w  = {n8, ~n8, n8};
            push_pix(w);
            send_range(w, 23, 0);
        end
        hold(1'b0, GAP);
        frame_end();
        check("t2_pv_count", pv_cnt - pv0, 32'd68);
        check("t2_fd_count", fd_cnt - fd0, 32'd2);
        check("t2_err_count", err_cnt - err0, 32'd0);
        check("t2_last_lit", {8'd0, pix.pix_data}, 32'h0003FC03);
        check("t2_queue_empty", exp_q.size(), 32'd0);

        // 100 ns glitch between bits 5 and 6 of 0x123456
        pv0 = pv_cnt; err0 = err_cnt;
        push_pix(24'h123456);
        send_range(24'h123456, 23, 18);
        hold(1'b1, 2);
        hold(1'b0, 4);
        send_range(24'h123456, 17, 0);
        hold(1'b0, GAP);
        frame_end();
        check("t3_data_lit", {8'd0, pix.pix_data}, 32'h00123456);
        check("t3_pv_count", pv_cnt - pv0, 32'd1);
        check("t3_err_count", err_cnt - err0, 32'd0);

        // Stuck high after 10 bits: one error, pixels ignored until a full gap
        pv0 = pv_cnt; fd0 = fd_cnt; err0 = err_cnt;
        send_range(24'hF0F0F0, 23, 14);
        hold(1'b1, 3000 * CLK_MHZ / 1000);
        hold(1'b0, 10);
        send_range(24'h555555, 23, 0);
        hold(1'b0, GAP);
        frame_end();
        check("t4_err_count", err_cnt - err0, 32'd1);
        check("t4_pv_before", pv_cnt - pv0, 32'd0);
        push_pix(24'h0F1E2D);
        send_range(24'h0F1E2D, 23, 0);
        hold(1'b0, GAP);
        frame_end();
        check("t4_pv_after", pv_cnt - pv0, 32'd1);
        check("t4_fd_count", fd_cnt - fd0, 32'd1);
        check("t4_data_lit", {8'd0, pix.pix_data}, 32'h000F1E2D);

        // 12 bits then a gap: bit_err with frame_done, no pixel
        pv0 = pv_cnt; fd0 = fd_cnt; err0 = err_cnt; both0 = both_cnt;
        send_range(24'hABCDEF, 23, 12);
        hold(1'b0, GAP);
        frame_end();
        check("t5_both", both_cnt - both0, 32'd1);
        check("t5_err_count", err_cnt - err0, 32'd1);
        check("t5_fd_count", fd_cnt - fd0, 32'd1);
        check("t5_pv_count", pv_cnt - pv0, 32'd0);

        // Reset mid-pixel: outputs clear, the next frame needs a full gap first
        pv0 = pv_cnt; fd0 = fd_cnt; err0 = err_cnt;
        send_range(24'h777777, 23, 14);
        hold(1'b1, 5);
        reset_ = 1'b0;
        din    = 1'b0;
        repeat (3) @(posedge osc_clk);
        #1;
        check("t6_rst_pix_valid", {31'd0, pix.pix_valid}, 32'd0);
        check("t6_rst_pix_data", {8'd0, pix.pix_data}, 32'd0);
        check("t6_rst_pix_idx", {24'd0, pix.pix_idx}, 32'd0);
        check("t6_rst_frame_done", {31'd0, pix.frame_done}, 32'd0);
        check("t6_rst_bit_err", {31'd0, pix.bit_err}, 32'd0);
        reset_ = 1'b1;
        frame_end();
        send_range(24'h112233, 23, 0);
        hold(1'b0, GAP);
        check("t6_pv_ignored", pv_cnt - pv0, 32'd0);
        push_pix(24'h445566);
        send_range(24'h445566, 23, 0);
        hold(1'b0, GAP);
        frame_end();
        check("t6_pv_count", pv_cnt - pv0, 32'd1);
        check("t6_fd_count", fd_cnt - fd0, 32'd1);
        check("t6_err_count", err_cnt - err0, 32'd0);

`ifdef WS2812_RX_FWD_EN
        // Chain forwarding: downstream sees pixels 1 and 2 only
        begin
            pix_t dp;
            ds_arm = 1'b1;
            fwd_watch = 1'b1;
            push_pix(24'hC0FFEE);
            send_range(24'hC0FFEE, 23, 0);
            fwd_watch = 1'b0;
            push_pix(24'h13579B);
            dp.data = 24'h13579B; dp.idx = 8'd0; ds_q.push_back(dp);
            send_range(24'h13579B, 23, 0);
            push_pix(24'h2468AC);
            dp.data = 24'h2468AC; dp.idx = 8'd1; ds_q.push_back(dp);
            send_range(24'h2468AC, 23, 0);
            hold(1'b0, GAP);
            frame_end();
            check("t7_dout_pix0", dout_hi, 32'd0);
            check("t7_ds_pv", ds_pv, 32'd2);
            check("t7_ds_queue", ds_q.size(), 32'd0);
        end
`endif

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Receiver/decoder for the single-wire WS2812 LED protocol. It samples an incoming serial data line, measures the width of each high pulse, and decodes the pulses into 24-bit pixel words in GRB order, MSB first. It also detects the low reset/latch gap that ends a frame. It sits at the board input of the LED matrix design and is used both as a loopback checker for our LED driver and as a front end for daisy-chained boards.

## Interface
Parameters:
- OSC_CLK_MHZ, 50, clock frequency in MHz
- MIN_HIGH_NS, 150, high pulses shorter than this are glitches and are ignored
- BIT_THRESH_NS, 600, high pulse at least this wide decodes as 1, otherwise 0
- MAX_HIGH_NS, 2000, high pulse reaching this width is an error
- RES_NS, 50000, low time that ends a frame

Ports:
- osc_clk  in  1  clock
- reset_  in  1  asynchronous, active-low reset
- din  in  1  WS2812 data line, asynchronous to osc_clk
- pix_valid  out  1  one-cycle strobe, pixel complete
- pix_data  out  24  last decoded pixel, GRB, bit 23 first received
- pix_idx  out  8  index within frame of the pixel on pix_data
- frame_done  out  1  one-cycle strobe at end of frame
- bit_err  out  1  one-cycle strobe on protocol error
- dout  out  1  regenerated downstream data, present only with WS2812_RX_FWD_EN

## Operation
- Each parameter converts to cycles as X_NS*OSC_CLK_MHZ/1000, with integer truncation. At the defaults: min = 7, thresh = 30, max = 100, res = 2500.
- din passes through a 2-flop synchronizer; din_s is the second flop. All decoding uses din_s and its registered previous value. The counter width is $clog2(res_cyc+1).
- The state machine has four states:
  - WAIT_RES (entered from reset): counts consecutive low cycles. At res_cyc it goes to IDLE; any high resets the count. This prevents decoding from the middle of a frame.
  - IDLE: on a rising edge, clears the counter and goes to HIGH.
  - HIGH: counts high cycles.
    - On a falling edge with count < min_cyc: no shift, go to LOW (glitch ignored).
    - Otherwise: shift in (count >= thresh_cyc) and increment bit_cntr (0..23). Go to LOW with the counter cleared.
    - If the count reaches max_cyc while still high: pulse bit_err, clear bit_cntr and pix_idx, go to WAIT_RES.
  - LOW: counts low cycles.
    - On a rising edge: go to HIGH.
    - If the count reaches res_cyc: pulse frame_done. If bit_cntr != 0, also pulse bit_err in the same cycle and discard the partial bits. Clear bit_cntr and pix_idx, go to IDLE.
- When the 24th bit is shifted in:
  - pix_data loads the completed word and pix_valid pulses.
  - pix_idx holds the index of that pixel, then increments. It saturates at 255; later pixels still report 255.
  - bit_cntr returns to 0.
- pix_data holds its value between strobes.

## Timing
- All outputs reset to 0, and the FSM resets to WAIT_RES. Asserting reset_ mid-frame aborts the pixel with no strobe; after release a full res_cyc low gap is required before decoding.
- Latency:
  - A din edge appears on din_s 2 cycles later.
  - pix_valid is high in the cycle after the cycle in which din_s first shows the falling edge of bit 23.
  - frame_done is high in the cycle after the low count reaches res_cyc.
- Pulse width measurement has ±1 cycle quantization plus synchronizer jitter. Thresholds compare as count >= limit.
- bit_err and frame_done may pulse in the same cycle; pix_valid never coincides with either.
- Minimum supported bit period is 2*min_cyc + 2 cycles.

## Configuration
- WS2812_RX_FWD_EN defined: dout exists and the block acts as a chain pixel.
  - dout is held 0 while pixel 0 is received.
  - From the rising edge of the first bit of pixel 1 until frame end, dout = din_s, registered 1 cycle.
  - dout returns to 0 at frame_done, on bit_err, and on reset.
- Not defined: dout port and forwarding logic are absent; decode behaviour is identical.

## Test plan
- Frame of one pixel 0xA5C33C (t0h 400 ns / t1h 800 ns, 1250 ns period), then 50 us low -> one pix_valid, pix_data = 0xA5C33C, pix_idx = 0, then frame_done; no bit_err.
- 64-pixel frame, pixel n = {n, ~n, n}, then gap, then a second frame -> 64 strobes with pix_idx 0..63, one frame_done per frame, pix_idx restarts at 0.
- 100 ns glitch inserted between bits 5 and 6 of 0x123456 -> data still 0x123456, no bit_err.
- din stuck high 3 us after 10 bits -> bit_err once, no pix_valid; valid pixels are ignored until 50 us low, then decoding resumes.
- 12 bits then 50 us low -> bit_err and frame_done in the same cycle, no pix_valid. reset_ asserted mid-pixel -> all outputs 0, next frame decodes only after the gap.
- WS2812_RX_FWD_EN: 3-pixel frame -> dout low during pixel 0, then dout reproduces pixels 1-2 delayed 3 cycles from din; a downstream ws2812_rx decodes 2 pixels.
